// File: rtl/cbu_interval_arb_if.sv
// ---------------------------------------------------------------------------
// cbu_interval_arb_if
//   Bundle of the signals between the interval arbiter, its four timer
//   clients, the tick prescaler and the shared 8-bit counter macro.
//
//   Client side  : REQ[3:0], LEN0..LEN3 (0 means 256), GNT[3:0], DONE[3:0], BUSY
//   Prescaler    : TICK
//   Counter side : CAO in; CTR_D, CTR_LD, CTR_EN, CTR_CAI, CTR_CS, CTR_PS out
//
//   slave  : view taken by the arbiter
//   master : view taken by whatever drives the clients/counter (bench or SoC)
// ---------------------------------------------------------------------------
interface cbu_interval_arb_if;
    logic [3:0] REQ;
    logic [7:0] LEN0;
    logic [7:0] LEN1;
    logic [7:0] LEN2;
    logic [7:0] LEN3;
    logic       TICK;
    logic       CAO;
    logic [3:0] GNT;
    logic [3:0] DONE;
    logic       BUSY;
    logic [7:0] CTR_D;
    logic       CTR_LD;
    logic       CTR_EN;
    logic       CTR_CAI;
    logic       CTR_CS;
    logic       CTR_PS;

    modport slave (
        input  REQ, LEN0, LEN1, LEN2, LEN3, TICK, CAO,
        output GNT, DONE, BUSY, CTR_D, CTR_LD, CTR_EN, CTR_CAI, CTR_CS, CTR_PS
    );

    modport master (
        output REQ, LEN0, LEN1, LEN2, LEN3, TICK, CAO,
        input  GNT, DONE, BUSY, CTR_D, CTR_LD, CTR_EN, CTR_CAI, CTR_CS, CTR_PS
    );
endinterface

// File: rtl/cbu_interval_arb.sv
// ---------------------------------------------------------------------------
// cbu_interval_arb
//   Round-robin scheduler sharing one external 8-bit up counter among four
//   interval requesters. The winner's length N is latched, the counter is
//   loaded with 256-N and counts on TICK; the counter's carry-out ends the
//   interval with a one-cycle DONE pulse to the winner. Dropping REQ while
//   counting aborts the interval without DONE.
//
//   Ports:
//     CLK   - clock, rising edge (also clocks the shared counter)
//     RSTN  - asynchronous active-low reset
//     bus   - cbu_interval_arb_if.slave: client REQ/LEN/GNT/DONE/BUSY,
//             TICK strobe, counter CAO and CTR_* control pins
// ---------------------------------------------------------------------------
module cbu_interval_arb (
    input  logic                  CLK,
    input  logic                  RSTN,
    cbu_interval_arb_if.slave     bus
);

    localparam logic [2:0] ST_INIT = 3'd0;
    localparam logic [2:0] ST_IDLE = 3'd1;
    localparam logic [2:0] ST_LOAD = 3'd2;
    localparam logic [2:0] ST_RUN  = 3'd3;
    localparam logic [2:0] ST_FIN  = 3'd4;
    localparam logic [2:0] ST_ABRT = 3'd5;

    logic [2:0] state;
    logic [2:0] state_nxt;
    logic [1:0] ptr;        // first requester searched in the next arbitration
    logic [1:0] win;        // latched winner index
    logic [7:0] lreg;       // latched interval length of the winner

    logic [1:0] rr_idx;
    logic [1:0] rr_win;
    logic       rr_found;
    logic [7:0] len_sel;
    logic [3:0] win_oh;
    logic       granted;

    // Round-robin search starting at ptr, wrapping through the 2-bit index.
    // NOTE: every always_comb output gets a default before any branch so no
    // path leaves it unassigned, which would infer a latch.
    always_comb begin
        rr_idx   = ptr;
        rr_win   = ptr;
        rr_found = 1'b0;
        for (int i = 0; i < 4; i++) begin
            rr_idx = ptr + 2'(i);
            if (!rr_found && bus.REQ[rr_idx]) begin
                rr_win   = rr_idx;
                rr_found = 1'b1;
            end
        end
    end

    always_comb begin
        case (rr_win)
            2'd0:    len_sel = bus.LEN0;
            2'd1:    len_sel = bus.LEN1;
            2'd2:    len_sel = bus.LEN2;
            default: len_sel = bus.LEN3;
        endcase
    end

    always_comb begin
        state_nxt = state;
        case (state)
            ST_INIT: state_nxt = ST_IDLE;
            ST_IDLE: if (rr_found) state_nxt = ST_LOAD;
            ST_LOAD: state_nxt = ST_RUN;
            // Terminal count takes priority over a simultaneous withdrawal.
            ST_RUN: begin
                if (bus.CAO)            state_nxt = ST_FIN;
                else if (!bus.REQ[win]) state_nxt = ST_ABRT;
            end
            ST_FIN:  state_nxt = ST_IDLE;
            ST_ABRT: state_nxt = ST_IDLE;
            default: state_nxt = ST_INIT;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values regardless of statement order.
    always_ff @(posedge CLK or negedge RSTN) begin
        if (!RSTN) begin
            state <= ST_INIT;
            ptr   <= 2'd0;
            win   <= 2'd0;
            lreg  <= 8'd0;
        end else begin
            state <= state_nxt;
            if (state == ST_IDLE && rr_found) begin
                win  <= rr_win;
                lreg <= len_sel;
                ptr  <= rr_win + 2'd1;
            end
        end
    end

    // Outputs decode from the state register and latched winner only;
    // CTR_CAI is the single combinational pass-through of TICK.
    always_comb begin
        win_oh  = 4'b0001 << win;
        granted = (state == ST_LOAD) || (state == ST_RUN) ||
                  (state == ST_FIN)  || (state == ST_ABRT);

        bus.GNT     = granted ? win_oh : 4'b0000;
        bus.DONE    = (state == ST_FIN) ? win_oh : 4'b0000;
        bus.BUSY    = (state != ST_IDLE);
        // Two's complement of N: the counter then wraps after exactly N
        // ticks, and N=0 loads 0x00 giving a full 256-tick interval.
        bus.CTR_D   = (state == ST_LOAD) ? (~lreg + 8'd1) : 8'd0;
        bus.CTR_LD  = (state == ST_LOAD);
        bus.CTR_EN  = (state == ST_RUN);
        bus.CTR_CAI = bus.TICK && (state == ST_RUN);
        bus.CTR_CS  = (state == ST_INIT) || (state == ST_FIN) || (state == ST_ABRT);
        bus.CTR_PS  = 1'b0;
    end

endmodule
